pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register. It is the successor to the fixed-field stage registers between datapath stages.
- Carries an opaque data payload plus a control bundle (write enables, load/store type, writeback select) across one stage.
- Adds a valid/ready handshake, stall back-pressure, flush/bubble insertion and an optional skid buffer that registers the ready path.
- Instantiated between EX/ME, ME/WB and any future stage boundaries.

---
 rtl/pipe_stage_reg.sv | 190 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register. Carries an opaque payload plus a control
//   bundle across one stage boundary with a valid/ready handshake, flush and
//   bubble insertion. With SKID=1 a second (skid) entry lets in_ready be a
//   flop, so the ready path is cut between stages.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
//   Upstream may not retract in_valid/in_data/in_ctrl while stalled; the
//   stage never presents a new out_* value while out_valid && !out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of all held entries (wins over everything)
//   in_valid   upstream entry present
//   in_ready   stage can accept this cycle
//   in_data    upstream payload   [DATA_W]
//   in_ctrl    upstream control   [CTRL_W]
//   out_valid  held entry presented downstream
//   out_ready  downstream accepts
//   out_data   held payload       [DATA_W] (stale when out_valid=0)
//   out_ctrl   held control       [CTRL_W] (zero when out_valid=0)
//   occupancy  held entries; for SKID=1 it is also the FSM state
//              (0=EMPTY, 1=HALF, 2=FULL) for observation
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  if (SKID == 0) begin : g_noskid
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_ctrl  <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else if (w_in_xfer) begin
        r_valid <= 1'b1;
        r_data  <= in_data;
        r_ctrl  <= in_ctrl;
      end else if (w_out_xfer) begin
        // Drained with nothing behind it: bubble, data left stale.
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end
    end

    // Ready passes straight through from downstream in this mode.
    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ctrl  = r_valid ? r_ctrl : '0;
    assign occupancy = {1'b0, r_valid};

  end else begin : g_skid
    typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_load_main;   // main <= input
    logic w_load_skid;   // skid <= input (main still stalled)
    logic w_move_skid;   // main <= skid, skid emptied
    logic w_drain;       // main emptied, nothing replaces it

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_EMPTY;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // Next-state logic
    always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
        w_state_nxt = ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_HALF;
          ST_HALF: begin
            if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_FULL;
            else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
          end
          ST_FULL:  if (w_out_xfer) w_state_nxt = ST_HALF;
          default:  w_state_nxt = ST_EMPTY;
        endcase
      end
    end

    // Datapath control decode
    always_comb begin
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_move_skid = 1'b0;
      w_drain     = 1'b0;
      if (!flush) begin
        case (r_state)
          ST_EMPTY: w_load_main = w_in_xfer;
          ST_HALF: begin
            w_load_main = w_in_xfer && w_out_xfer;
            w_load_skid = w_in_xfer && !w_out_xfer;
            w_drain     = w_out_xfer && !w_in_xfer;
          end
          ST_FULL:  w_move_skid = w_out_xfer;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_in_ready  <= 1'b1;
        r_main_data <= '0;
        r_main_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end else begin
        // Registered ready: accept next cycle unless we are about to be full.
        r_in_ready <= (w_state_nxt != ST_FULL);
        if (flush) begin
          r_main_ctrl <= '0;
          r_skid_ctrl <= '0;
        end else begin
          if (w_load_main) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_move_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
          end else if (w_drain) begin
            r_main_ctrl <= '0;
          end
          if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
          end else if (w_move_skid) begin
            r_skid_ctrl <= '0;
          end
        end
      end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main_data;
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign occupancy = r_state;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int W  = DW + CW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;

  logic          in_ready1, out_valid1;
  logic [DW-1:0] out_data1;
  logic [CW-1:0] out_ctrl1;
  logic [1:0]    occupancy1;

  logic          in_ready0, out_valid0;
  logic [DW-1:0] out_data0;
  logic [CW-1:0] out_ctrl0;
  logic [1:0]    occupancy0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .occupancy(occupancy1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .occupancy(occupancy0)
  );

  // ---------------- scoreboard ----------------
  // Reference: each stage is a FIFO of {ctrl,data}; depth 2 with ready meaning
  // "not full" (SKID=1), depth 1 with ready meaning "empty or draining" (SKID=0).
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] h;
    chk("s1_valid", 64'(out_valid1), 64'(exp_q1.size() > 0));
    chk("s1_occ", 64'(occupancy1), 64'(exp_q1.size()));
    chk("s1_ready", 64'(in_ready1), 64'(exp_q1.size() < 2));
    if (exp_q1.size() > 0) begin
      h = exp_q1[0];
      chk("s1_data", out_data1, h[DW-1:0]);
      chk("s1_ctrl", 64'(out_ctrl1), 64'(h[W-1:DW]));
    end else begin
      chk("s1_ctrl_gate", 64'(out_ctrl1), 64'd0);
    end
    chk("s0_valid", 64'(out_valid0), 64'(exp_q0.size() > 0));
    chk("s0_occ", 64'(occupancy0), 64'(exp_q0.size()));
    chk("s0_ready", 64'(in_ready0), 64'(exp_q0.size() == 0 || out_ready));
    if (exp_q0.size() > 0) begin
      h = exp_q0[0];
      chk("s0_data", out_data0, h[DW-1:0]);
      chk("s0_ctrl", 64'(out_ctrl0), 64'(h[W-1:DW]));
    end else begin
      chk("s0_ctrl_gate", 64'(out_ctrl0), 64'd0);
    end
  endtask

  // Advance both reference FIFOs by one clock edge.
  task automatic model_edge();
    bit o1, i1, o0, i0;
    if (flush) begin
      exp_q1.delete();
      exp_q0.delete();
    end else begin
      o1 = exp_q1.size() > 0 && out_ready;
      i1 = in_valid && exp_q1.size() < 2;
      o0 = exp_q0.size() > 0 && out_ready;
      i0 = in_valid && (exp_q0.size() == 0 || out_ready);
      if (o1) void'(exp_q1.pop_front());
      if (i1) exp_q1.push_back({in_ctrl, in_data});
      if (o0) void'(exp_q0.pop_front());
      if (i0) exp_q0.push_back({in_ctrl, in_data});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Check at the falling edge, then take one rising edge; returns 1 after it.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int n_bub;
  logic [4:0] bub_pat;

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid1), 64'd0);
    chk("rst_data", out_data1, 64'd0);
    chk("rst_ctrl", 64'(out_ctrl1), 64'd0);
    chk("rst_occ", 64'(occupancy1), 64'd0);
    chk("rst_data0", out_data0, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready1), 64'd1);

    // 1: streaming at full rate
    drive(1'b1, 64'h10, 8'h01, 1'b1, 1'b0); step();
    chk("t1_d10", out_data1, 64'h10);
    drive(1'b1, 64'h11, 8'h02, 1'b1, 1'b0); step();
    chk("t1_d11", out_data1, 64'h11);
    chk("t1_occ", 64'(occupancy1), 64'd1);
    drive(1'b1, 64'h12, 8'h03, 1'b1, 1'b0); step();
    chk("t1_d12", out_data1, 64'h12);
    chk("t1_rdy", 64'(in_ready1), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    chk("t1_empty", 64'(out_valid1), 64'd0);

    // 2: back-pressure fills main + skid, then drains in order
    drive(1'b1, 64'hA0, 8'h10, 1'b0, 1'b0); step();
    drive(1'b1, 64'hA1, 8'h11, 1'b0, 1'b0); step();
    chk("t2_occ2", 64'(occupancy1), 64'd2);
    chk("t2_rdy0", 64'(in_ready1), 64'd0);
    drive(1'b1, 64'hA2, 8'h12, 1'b0, 1'b0); step();
    chk("t2_hold", out_data1, 64'hA0);
    drive(1'b1, 64'hA2, 8'h12, 1'b1, 1'b0); step();
    chk("t2_a1", out_data1, 64'hA1);
    step();
    chk("t2_a2", out_data1, 64'hA2);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    chk("t2_drained", 64'(occupancy1), 64'd0);

    // 3: flush while FULL discards the presented entry too
    drive(1'b1, 64'hB0, 8'h21, 1'b0, 1'b0); step();
    drive(1'b1, 64'hB1, 8'h22, 1'b0, 1'b0); step();
    drive(1'b1, 64'hCC, 8'hFF, 1'b0, 1'b1); step();
    chk("t3_valid", 64'(out_valid1), 64'd0);
    chk("t3_ctrl", 64'(out_ctrl1), 64'd0);
    chk("t3_occ", 64'(occupancy1), 64'd0);
    chk("t3_rdy", 64'(in_ready1), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step();

    // 4: SKID=0 combinational ready
    drive(1'b1, 64'hC0, 8'h31, 1'b0, 1'b0); step();
    drive(1'b1, 64'hC1, 8'h32, 1'b0, 1'b0);
    #1 chk("t4_rdy0", 64'(in_ready0), 64'd0);
    out_ready = 1'b1;
    #1 chk("t4_rdy1", 64'(in_ready0), 64'd1);
    step();
    chk("t4_load", out_data0, 64'hC1);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step();

    // 5: asynchronous reset while FULL
    drive(1'b1, 64'hD0, 8'h41, 1'b0, 1'b0); step();
    drive(1'b1, 64'hD1, 8'h42, 1'b0, 1'b0); step();
    chk("t5_full", 64'(occupancy1), 64'd2);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(out_valid1), 64'd0);
    chk("t5_occ", 64'(occupancy1), 64'd0);
    chk("t5_ctrl", 64'(out_ctrl1), 64'd0);
    chk("t5_data", out_data1, 64'd0);
    chk("t5_occ0", 64'(occupancy0), 64'd0);
    exp_q1.delete();
    exp_q0.delete();
    #1 rst_n = 1'b1;
    drive(1'b1, 64'h55, 8'h05, 1'b1, 1'b0); step();
    chk("t5_55", out_data1, 64'h55);
    chk("t5_55v", 64'(out_valid1), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();

    // 6: one-cycle bubble inside a stream
    bub_pat = 5'b11011;
    n_bub = 0;
    for (int i = 4; i >= 0; i--) begin
      drive(bub_pat[i], 64'(32'hE0 + i), 8'h3C, 1'b1, 1'b0);
      step();
      if (!out_valid1) begin
        n_bub++;
        chk("t6_ctrl", 64'(out_ctrl1), 64'd0);
      end
    end
    chk("t6_bubbles", 64'(n_bub), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();

    // random traffic against the reference FIFOs
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      step();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step(); step();
    @(negedge clk);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
